// File: rtl/score_display_mux.sv
// Two-player score to 4-digit multiplexed 7-segment display, with frame-synchronous score updates.
// Optional SCORE_BLINK_EN: a player's digits blink while that player's score equals WIN_SCORE.
module score_display_mux #(
  parameter int         REFRESH_DIV = 50000,
  parameter int         BLINK_DIV   = 25000000,
  parameter logic [3:0] WIN_SCORE   = 4'd15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] score0,
  input  logic [3:0] score1,
  input  logic       upd,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       frame
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    stg0, stg1, sh0, sh1;
  logic          pending;
  logic          wrap, boundary;

  assign wrap     = (cnt == CW'(REFRESH_DIV - 1));
  assign boundary = wrap && (idx == 2'd3);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

`ifdef SCORE_BLINK_EN
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] bcnt;
  logic          phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (bcnt == BW'(BLINK_DIV - 1)) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{BLINK_DIV[0], WIN_SCORE};
`endif

  // idx[1] picks the player, idx[0]=0 is the tens digit
  logic [3:0] v;
  logic [6:0] glyph;
  logic [7:0] seg_nxt;
  logic [3:0] an_nxt;

  always_comb begin
    v      = idx[1] ? sh1 : sh0;
    glyph  = 7'h7F;
    if (!idx[0]) glyph = (v >= 4'd10) ? 7'h79 : 7'h7F;
    else         glyph = seg7((v >= 4'd10) ? v - 4'd10 : v);
    seg_nxt = {(idx != 2'd1), glyph};
`ifdef SCORE_BLINK_EN
    if (v == WIN_SCORE && !phase) seg_nxt = 8'hFF;
`endif
    an_nxt = ~(4'b1000 >> idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      idx     <= 2'd0;
      stg0    <= 4'd0;
      stg1    <= 4'd0;
      sh0     <= 4'd0;
      sh1     <= 4'd0;
      pending <= 1'b0;
      seg     <= 8'hFF;
      an      <= 4'b1111;
      frame   <= 1'b0;
    end else begin
      cnt   <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= idx + 2'd1;
      frame <= boundary;
      // an update landing on the boundary itself bypasses staging
      if (boundary && upd) begin
        sh0     <= score0;
        sh1     <= score1;
        pending <= 1'b0;
      end else if (boundary && pending) begin
        sh0     <= stg0;
        sh1     <= stg1;
        pending <= 1'b0;
      end else if (upd) begin
        stg0    <= score0;
        stg1    <= score1;
        pending <= 1'b1;
      end
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule
